// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one 4-bit ripple slice reused LSB nibble first, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   busy,
   output logic                   ovf
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic [W-1:0]    sum_r;
   logic            carry_r;
   logic            cout_r;
   logic [IW-1:0]   idx_r;
   logic [3:0]      nib_a_s;
   logic [3:0]      nib_b_s;
   logic [4:0]      nib_sum_s;
   logic            last_s;
   logic            accept_s;

   // Shared 4-bit slice: selects the current operand nibbles and adds them with the held carry.
   always_comb begin
      nib_a_s   = a_r[{idx_r, 2'b00} +: 4];
      nib_b_s   = b_r[{idx_r, 2'b00} +: 4];
      nib_sum_s = {1'b0, nib_a_s} + {1'b0, nib_b_s} + {4'b0000, carry_r};
      last_s    = (idx_r == IW'(NIBBLES - 1));
      accept_s  = (state_r == IDLE) && in_valid;
   end

   // Next-state decode for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_s = RUN;
            else          state_s = IDLE;
         end
         RUN: begin
            if (last_s) state_s = DONE;
            else        state_s = RUN;
         end
         DONE: begin
            if (out_ready) state_s = IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_s;
   end

   // Operand capture on accept, then one sum nibble per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         idx_r   <= '0;
      end else if (accept_s) begin
         a_r     <= a;
         b_r     <= b;
         sum_r   <= '0;
         carry_r <= cin;
         cout_r  <= 1'b0;
         idx_r   <= '0;
      end else if (state_r == RUN) begin
         sum_r[{idx_r, 2'b00} +: 4] <= nib_sum_s[3:0];
         carry_r                    <= nib_sum_s[4];
         idx_r                      <= idx_r + 1'b1;
         if (last_s) cout_r <= nib_sum_s[4];
      end
   end

`ifdef NSA_OVERFLOW_EN
   logic [3:0] msb_add_s;
   logic       ovf_r;

   // Carry into bit W-1 comes from the low three bits of the top nibble.
   always_comb begin
      msb_add_s = {1'b0, nib_a_s[2:0]} + {1'b0, nib_b_s[2:0]} + {3'b000, carry_r};
   end

   // Overflow is captured on the final nibble and held through DONE.
   always_ff @(posedge clk) begin
      if (rst)                          ovf_r <= 1'b0;
      else if (accept_s)                ovf_r <= 1'b0;
      else if (state_r == RUN && last_s) ovf_r <= msb_add_s[3] ^ nib_sum_s[4];
   end

   assign ovf = ovf_r;
`else
   assign ovf = 1'b0;
`endif

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign busy      = (state_r != IDLE);
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): vector table plus scoreboard,
// with hand-written backpressure and mid-operation reset sequences.
module tb_nibble_serial_adder;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;
`ifdef NSA_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         ovf;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      vec_t         v;
      logic [W:0]   t;
      t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      v.a  = x;
      v.b  = y;
      v.cin = c;
      v.s  = t[W-1:0];
      v.co = t[W];
      v.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      return v;
   endfunction

   task automatic sb_compare(input string tag);
      exp_t e;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_sum"},  32'(sum),  32'(e.s));
         chk({tag, "_cout"}, 32'(cout), 32'(e.co));
         chk({tag, "_ovf"},  32'(ovf),  32'(e.ov));
      end
   endtask

   // Apply one operand pair; hold > 0 keeps out_ready low that many cycles in DONE.
   task automatic apply(input vec_t v, input string tag, input int hold);
      int           cyc;
      logic [W-1:0] mask;
      logic [W-1:0] ones;
      ones = '1;
      @(negedge clk);
      out_ready = (hold == 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      a        = v.a;
      b        = v.b;
      cin      = v.cin;
      sb.push_back('{s: v.s, co: v.co, ov: OVF_EN & v.ov});
      @(negedge clk);
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom);
      cyc      = 0;
      while (!out_valid && cyc < 20) begin
         mask = ~(ones << (4 * cyc));
         chk({tag, "_partial"}, 32'(sum), 32'(v.s & mask));
         chk({tag, "_busy"},    32'(busy), 32'd1);
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(NIBBLES));
      for (int h = 0; h < hold; h++) begin
         chk({tag, "_hold_sum"},   32'(sum),       32'(v.s));
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
         in_valid = (h == 1 || h == 2);
         a        = 16'h1111;
         b        = 16'h2222;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      sb_compare(tag);
      @(negedge clk);
      chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready),  32'd1);
      chk({tag, "_idle"},       32'(busy),      32'd0);
   endtask

   vec_t tbl[8];

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cin       = 1'b0;

      tbl[0] = '{a: 16'h0006, b: 16'h0004, cin: 1'b0, s: 16'h000A, co: 1'b0, ov: 1'b0};
      tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b0};
      tbl[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0, ov: 1'b1};
      tbl[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b1};
      tbl[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, co: 1'b1, ov: 1'b0};
      for (int i = 5; i < 8; i++) tbl[i] = model(W'($urandom), W'($urandom), 1'($urandom));

      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("vec%0d", i), 0);

      // Backpressure: result held 5 cycles while a second pair is offered and ignored.
      apply('{a: 16'h0F0F, b: 16'h0101, cin: 1'b0, s: 16'h1010, co: 1'b0, ov: 1'b0}, "bp", 5);
      @(negedge clk);
      chk("bp_not_accepted", 32'(busy), 32'd0);

      // Reset after E2 aborts the operation.
      in_valid = 1'b1;
      a        = 16'h5555;
      b        = 16'h1111;
      cin      = 1'b0;
      sb.push_back('{s: 16'h6666, co: 1'b0, ov: 1'b0});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_partial", 32'(sum), 32'h0066);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      chk("abort_idle_valid", 32'(out_valid), 32'd0);
      chk("abort_idle_sum",   32'(sum),       32'd0);
      chk("abort_idle_busy",  32'(busy),      32'd0);
      chk("abort_idle_ready", 32'(in_ready),  32'd1);
      apply('{a: 16'h1234, b: 16'h1111, cin: 1'b1, s: 16'h2346, co: 1'b0, ov: 1'b0}, "after_rst", 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
